// File: rtl/uart_board_loader.sv
// uart_board_loader: parses one Sudoku frame from the UART rx stream,
// writes digit cells to the board RAM and answers with ACK or NAK.
module uart_board_loader #(
   parameter int          CELLS          = 81,
   parameter logic [7:0]  START_BYTE     = 8'h53,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B,
   parameter logic [7:0]  NAK_BYTE       = 8'h4E,
   parameter int          TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_error,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_error,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       cell_we,
   output logic [6:0] cell_addr,
   output logic [3:0] cell_value,
   output logic       board_loaded,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0]    I_LAST = 7'(CELLS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_SEND
   } state_t;

   state_t        state_q;
   logic [6:0]    idx_q;
   logic [TW-1:0] tmr_q;
   logic          we_q;
   logic [6:0]    addr_q;
   logic [3:0]    val_q;
   logic          loaded_q;
   logic          txv_q;
   logic [7:0]    txd_q;

   logic accept;
   logic is_digit;

   // Handshake and byte classification.
   assign rx_ready = !reset && (state_q != S_SEND);
   assign accept   = rx_valid && rx_ready;
   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

   assign tx_data      = txd_q;
   assign tx_valid     = txv_q;
   assign tx_error     = 1'b0;
   assign cell_we      = we_q;
   assign cell_addr    = addr_q;
   assign cell_value   = val_q;
   assign board_loaded = loaded_q;
   assign busy         = (state_q != S_IDLE);

   // Frame FSM: idle hunt for start, cell receive with timeout, response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         tmr_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         val_q    <= '0;
         loaded_q <= 1'b0;
         txv_q    <= 1'b0;
         txd_q    <= '0;
      end else begin
         we_q     <= 1'b0;
         loaded_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept && !rx_error && rx_data == START_BYTE) begin
                  state_q <= S_RECV;
                  idx_q   <= '0;
                  tmr_q   <= '0;
               end
            end
            S_RECV: begin
               if (accept) begin
                  if (rx_error || !is_digit) begin
                     state_q <= S_SEND;
                     txv_q   <= 1'b1;
                     txd_q   <= NAK_BYTE;
                  end else begin
                     we_q   <= 1'b1;
                     addr_q <= idx_q;
                     val_q  <= rx_data[3:0];
                     idx_q  <= idx_q + 7'd1;
                     tmr_q  <= '0;
                     if (idx_q == I_LAST) begin
                        loaded_q <= 1'b1;
                        state_q  <= S_SEND;
                        txv_q    <= 1'b1;
                        txd_q    <= ACK_BYTE;
                     end
                  end
               end else if (tmr_q == T_LAST) begin
                  state_q <= S_SEND;
                  txv_q   <= 1'b1;
                  txd_q   <= NAK_BYTE;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  txv_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_board_loader.sv
// tb_uart_board_loader: random and directed frames checked against a
// frame-level model of the loader.
module tb_uart_board_loader;

   localparam int CELLS = 81;
   localparam int TO    = 100;
   localparam logic [7:0] SB  = 8'h53;
   localparam logic [7:0] ACK = 8'h4B;
   localparam logic [7:0] NAK = 8'h4E;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_error = 1'b0;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_error;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       cell_we;
   logic [6:0] cell_addr;
   logic [3:0] cell_value;
   logic       board_loaded;
   logic       busy;

   uart_board_loader #(
      .CELLS(CELLS),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_error(rx_error),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .tx_data(tx_data),
      .tx_error(tx_error),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .cell_we(cell_we),
      .cell_addr(cell_addr),
      .cell_value(cell_value),
      .board_loaded(board_loaded),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Comparison helper used by every check in the bench.
   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stimulus byte list and expected/observed cell writes.
   logic [7:0]  sb[$];
   bit          se[$];
   logic [10:0] exp_w[$];
   logic [10:0] got_w[$];
   int          got_loaded;
   int          loaded_bad;

   // Observe the board RAM side away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (cell_we) got_w.push_back({cell_addr, cell_value});
         if (board_loaded) begin
            got_loaded++;
            if (!(cell_we && cell_addr == 7'(CELLS - 1))) loaded_bad++;
         end
      end
   end

   task automatic clr();
      sb.delete();
      se.delete();
   endtask

   task automatic pb(input logic [7:0] b, input bit e);
      sb.push_back(b);
      se.push_back(e);
   endtask

   task automatic p_digits(input int n);
      for (int i = 0; i < n; i++) pb(8'(8'h30 + $urandom_range(9, 0)), 1'b0);
   endtask

   // Frame-level reference: junk until a clean 'S', then digits become
   // consecutive cells; a bad byte NAKs, CELLS digits ACK, running out
   // of bytes means the frame times out.
   task automatic model(output logic [7:0] resp, output int loaded,
                        output bit tmo);
      bit inf;
      bit done;
      int n;
      exp_w.delete();
      inf = 0; done = 0; n = 0;
      resp = NAK; loaded = 0; tmo = 0;
      for (int i = 0; i < sb.size(); i++) begin
         if (!inf) begin
            if (sb[i] == SB && !se[i]) inf = 1;
         end else if (se[i] || sb[i] < 8'h30 || sb[i] > 8'h39) begin
            done = 1;
            break;
         end else begin
            exp_w.push_back({7'(n), 4'(sb[i] - 8'h30)});
            n++;
            if (n == CELLS) begin
               resp = ACK;
               loaded = 1;
               done = 1;
               break;
            end
         end
      end
      if (!done) tmo = 1;
   endtask

   task automatic drive_bytes(input int gapmax);
      int nr;
      got_w.delete();
      got_loaded = 0;
      loaded_bad = 0;
      nr = 0;
      for (int i = 0; i < sb.size(); i++) begin
         int g;
         g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
         rx_valid = 1'b0;
         repeat (g) @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = sb[i];
         rx_error = se[i];
         if (!rx_ready) nr++;
         @(negedge clk);
      end
      rx_valid = 1'b0;
      rx_error = 1'b0;
      check("rx_ready_during_frame", nr, 0);
   endtask

   task automatic run_frame(input int hold, input int gapmax);
      logic [7:0] resp;
      logic [7:0] d;
      int ld;
      bit tmo;
      int w;
      int bad;
      model(resp, ld, tmo);
      drive_bytes(gapmax);
      w = 0;
      while (!tx_valid && w < TO + 20) begin
         @(negedge clk);
         w++;
      end
      check("tx_valid_rise", tx_valid, 1);
      check(tmo ? "timeout_latency" : "resp_latency", w, tmo ? TO : 0);
      check("tx_data", tx_data, resp);
      check("tx_error", tx_error, 0);
      check("rx_ready_send", rx_ready, 0);
      check("busy_send", busy, 1);
      d = tx_data;
      bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (tx_valid !== 1'b1 || tx_data !== d || rx_ready !== 1'b0) bad++;
      end
      if (hold > 0) check("send_hold_stable", bad, 0);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check("tx_valid_fall", tx_valid, 0);
      check("rx_ready_after", rx_ready, 1);
      check("busy_idle", busy, 0);
      check("n_writes", got_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
         check("cell_write", got_w[i], exp_w[i]);
      check("board_loaded_cnt", got_loaded, ld);
      check("board_loaded_align", loaded_bad, 0);
   endtask

   task automatic check_reset_vals();
      check("rst_rx_ready", rx_ready, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_error", tx_error, 0);
      check("rst_cell_we", cell_we, 0);
      check("rst_cell_addr", cell_addr, 0);
      check("rst_cell_value", cell_value, 0);
      check("rst_board_loaded", board_loaded, 0);
      check("rst_busy", busy, 0);
   endtask

   string puz;

   initial begin
      puz = {"530070000600195000098000060800060003",
             "400803001700020006060000280000419005000080079"};
      repeat (3) @(negedge clk);
      check_reset_vals();
      reset = 1'b0;
      @(negedge clk);
      check("idle_rx_ready", rx_ready, 1);

      // Known puzzle frame.
      clr();
      pb(SB, 0);
      for (int i = 0; i < CELLS; i++) pb(puz[i], 0);
      run_frame(0, 0);

      // Junk before start, then a full frame.
      clr();
      pb(8'h41, 0);
      pb(8'h0A, 0);
      pb(SB, 1);
      pb(SB, 0);
      p_digits(CELLS);
      run_frame(2, 0);

      // Bad byte after 10 digits.
      clr();
      pb(SB, 0);
      p_digits(10);
      pb(8'h58, 0);
      run_frame(5, 0);

      // Silence after 5 digits.
      clr();
      pb(SB, 0);
      p_digits(5);
      run_frame(0, 0);

      // rx_error in RECV, response held off for 20 cycles.
      clr();
      pb(SB, 0);
      p_digits(7);
      pb(8'h35, 1);
      run_frame(20, 0);

      // Repeated start byte is a bad byte.
      clr();
      pb(SB, 0);
      p_digits(3);
      pb(SB, 0);
      run_frame(1, 0);

      // Reset in the middle of a frame.
      clr();
      pb(SB, 0);
      p_digits(40);
      drive_bytes(0);
      #1 reset = 1'b1;
      #2;
      check_reset_vals();
      check("rst_mid_writes", got_w.size(), 40);
      check("rst_mid_loaded", got_loaded, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_no_tx", tx_valid, 0);
      clr();
      pb(SB, 0);
      p_digits(CELLS);
      run_frame(0, 0);

      // Randomised frames.
      for (int f = 0; f < 24; f++) begin
         int kind;
         int k;
         clr();
         repeat ($urandom_range(3, 0)) begin
            logic [7:0] j;
            bit e;
            j = 8'($urandom);
            e = 1'($urandom);
            if (j == SB && !e) j = 8'h41;
            pb(j, e);
         end
         pb(SB, 0);
         kind = int'($urandom_range(2, 0));
         k = int'($urandom_range(CELLS - 1, 0));
         if (kind == 0) begin
            p_digits(CELLS);
         end else if (kind == 1) begin
            logic [7:0] b;
            p_digits(k);
            if ($urandom_range(1, 0) == 0) begin
               pb(8'($urandom), 1'b1);
            end else begin
               b = 8'($urandom);
               while (b >= 8'h30 && b <= 8'h39) b = 8'($urandom);
               pb(b, 1'b0);
            end
         end else begin
            p_digits(k);
         end
         run_frame(int'($urandom_range(4, 0)), 2);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_board_loader.md
# uart_board_loader

Consumes the received-byte Avalon-ST stream from the RS232 UART core and parses one Sudoku puzzle frame per transfer. Valid digits are written into the board memory as cells. The block then answers with a one-byte ACK or NAK on the UART transmit stream. It sits between the UART core's from_uart/to_uart ports and the board RAM/solver.

## Interface
Parameters:
- CELLS, 81, cells per frame
- START_BYTE, 8'h53 ('S'), frame start marker
- ACK_BYTE, 8'h4B ('K'), sent after a complete valid frame
- NAK_BYTE, 8'h4E ('N'), sent after a bad byte or a timeout
- TIMEOUT_CYCLES, 50_000_000, maximum idle cycles between bytes inside a frame

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high
- rx_data  in  8  byte from UART (from_uart_data)
- rx_error  in  1  UART framing/parity error for this byte
- rx_valid  in  1  rx byte present
- rx_ready  out  1  block accepts rx byte
- tx_data  out  8  response byte (to_uart_data)
- tx_error  out  1  constant 0
- tx_valid  out  1  response byte present
- tx_ready  in  1  UART accepts tx byte
- cell_we  out  1  one-cycle write strobe to board RAM
- cell_addr  out  7  cell index 0..CELLS-1
- cell_value  out  4  0 = empty, 1..9 = given
- board_loaded  out  1  one-cycle pulse when a full frame is written
- busy  out  1  high in RECV and SEND

## Operation
- Accept on an rx byte = rising edge with rx_valid && rx_ready. Tx handshake = rising edge with tx_valid && tx_ready.
- rx_ready = !reset && (state is IDLE or RECV). It is 0 in SEND, so rx and tx activity never overlap.
- IDLE:
  - Accepting START_BYTE with rx_error = 0 → RECV, with index = 0 and timer = 0.
  - Every other byte, including error bytes, is accepted and discarded.
- RECV, on an accepted byte:
  - rx_error = 1 or byte outside 0x30..0x39 → result = NAK, go to SEND, no write. A repeated 'S' also counts as a bad byte.
  - Otherwise register cell_we = 1, cell_addr = index, cell_value = byte − 0x30; then index += 1 and timer = 0.
  - If index == CELLS−1 at acceptance → result = ACK, board_loaded pulses, go to SEND.
- RECV timeout: timer increments on every cycle without an accept. At timer == TIMEOUT_CYCLES−1 → result = NAK, go to SEND. Timer width is clog2(TIMEOUT_CYCLES).
- SEND: tx_valid = 1 and tx_data = ACK_BYTE or NAK_BYTE, held stable until the handshake; then → IDLE.
- Partial writes from an aborted frame stay in the board RAM. The consumer uses only board_loaded to qualify the board.
- busy = (state != IDLE).

## Timing
- Reset values: state = IDLE, index = 0, timer = 0, cell_we = 0, cell_addr = 0, cell_value = 0, board_loaded = 0, tx_valid = 0, tx_data = 0, tx_error = 0, busy = 0, rx_ready = 0 while reset is high.
- cell_we, cell_addr and cell_value are registered. They are valid the cycle after the accepting edge, for exactly one cycle.
- board_loaded is asserted in the same cycle as the last cell_we (addr CELLS−1).
- tx_valid rises the cycle after the terminating accept or the timeout cycle.
- tx_valid falls the cycle after the tx handshake. rx_ready returns to 1 in that same cycle.
- Throughput: one byte per cycle when rx_valid is held high. No bubbles in RECV.
- Reset asserted mid-frame or in SEND: immediate return to IDLE. The pending response is dropped and no board_loaded is issued.
- Timeout and a byte accept on the same cycle: the accept wins and timer resets.

## Test plan
- 'S' followed by the 81 bytes "530070000…" (see below) → 81 cell_we pulses with addr 0..80 and values matching the digits; board_loaded with addr 80; tx 0x4B; then IDLE.
  - Frame detail: "530070000" then 72 more digits.
- Bytes 0x41, 0x0A before 'S' → discarded with no writes. The following valid frame still ACKs.
- 'S', 10 digits, then 0x58 → 10 writes, no board_loaded, tx 0x4E, rx_ready = 0 until the tx handshake.
- 'S', 5 digits, then silence with TIMEOUT_CYCLES = 100 → tx 0x4E exactly 100 cycles after the 5th accept edge.
- tx_ready held 0 for 20 cycles during SEND → tx_valid and tx_data stay stable and rx_ready stays 0. A byte with rx_error = 1 in RECV → NAK.
- reset asserted at cell 40 → all outputs return to reset values. A new frame afterwards starts at addr 0 and ACKs.
